data_mem_io: RTL

Data-memory responder for the LEGLite single-cycle core: the target end of the core's daddr/dread/dwrite/dwdata/ddata port. It contains word-addressed data RAM and a small memory-mapped I/O page: an output port, a synchronized input port, and a down-counting timer with a sticky expiry flag. Reads are combinational so the core sees load data in the same cycle. Writes and all side effects take effect on the rising clock edge.

---
 rtl/data_mem_io.sv | 118 +++++++++++
 1 files changed

// File: rtl/data_mem_io.sv
// Data-memory responder for the LEGLite core: word RAM plus a small I/O page
// (output port, synchronized input port, down-counting timer with sticky status).
module data_mem_io #(
  parameter int unsigned RAM_WORDS = 128,
  parameter logic [15:0] IO_BASE   = 16'hFFF0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] daddr,
  input  logic        dread,
  input  logic        dwrite,
  input  logic [15:0] dwdata,
  output logic [15:0] ddata,
  input  logic [15:0] io_in,
  output logic [15:0] io_out,
  output logic        timer_irq
);

  localparam int unsigned AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;

  typedef enum logic [2:0] {
    IO_OUT    = 3'd0,
    IO_IN     = 3'd1,
    IO_LOAD   = 3'd2,
    IO_COUNT  = 3'd3,
    IO_CTRL   = 3'd4,
    IO_STATUS = 3'd5
  } io_reg_e;

  logic [15:0] mem_q [RAM_WORDS];
  logic [15:0] out_q, sync1_q, sync2_q, load_q, count_q;
  logic [2:0]  ctrl_q;
  logic [1:0]  status_q;

  logic [15:0] count_d;
  logic [2:0]  ctrl_d;
  logic [1:0]  status_d;

  logic [15:0] io_off;
  logic        is_ram, is_io, wr_io, expire, st_read;
  io_reg_e     io_sel;

  always_comb begin
    io_off = daddr - IO_BASE;
    is_ram = (32'(daddr) < RAM_WORDS);
    is_io  = (daddr >= IO_BASE) && (io_off < 16'd6);
    io_sel = io_reg_e'(io_off[2:0]);
  end

  always_comb begin
    ddata = '0;
    if (is_ram) begin
      ddata = mem_q[daddr[AW-1:0]];
    end else if (is_io) begin
      case (io_sel)
        IO_OUT:    ddata = out_q;
        IO_IN:     ddata = sync2_q;
        IO_LOAD:   ddata = load_q;
        IO_COUNT:  ddata = count_q;
        IO_CTRL:   ddata = {13'b0, ctrl_q};
        IO_STATUS: ddata = {14'b0, status_q};
        default:   ddata = '0;
      endcase
    end
  end

  // Expiry wins over the read-clear for the expired bit only; overrun is
  // cleared by the read even if this edge would otherwise set it.
  always_comb begin
    wr_io   = dwrite && is_io;
    expire  = ctrl_q[0] && (count_q == '0);
    st_read = dread && is_io && (io_sel == IO_STATUS);

    count_d = count_q;
    if (wr_io && (io_sel == IO_LOAD)) begin
      count_d = dwdata;
    end else if (ctrl_q[0]) begin
      if (count_q != '0) count_d = count_q - 16'd1;
      else if (ctrl_q[1]) count_d = load_q;
    end

    ctrl_d = ctrl_q;
    if (wr_io && (io_sel == IO_CTRL)) ctrl_d = dwdata[2:0];
    else if (expire && !ctrl_q[1])   ctrl_d[0] = 1'b0;

    status_d = status_q;
    if (st_read)     status_d = {1'b0, expire};
    else if (expire) status_d = {status_q[1] | status_q[0], 1'b1};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_q    <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      load_q   <= '0;
      count_q  <= '0;
      ctrl_q   <= '0;
      status_q <= '0;
    end else begin
      sync1_q  <= io_in;
      sync2_q  <= sync1_q;
      count_q  <= count_d;
      ctrl_q   <= ctrl_d;
      status_q <= status_d;
      if (wr_io && (io_sel == IO_OUT))  out_q  <= dwdata;
      if (wr_io && (io_sel == IO_LOAD)) load_q <= dwdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && dwrite && is_ram) mem_q[daddr[AW-1:0]] <= dwdata;
  end

  assign io_out    = out_q;
  assign timer_irq = status_q[0] & ctrl_q[2];

endmodule
